// File: rtl/exp_pkg.sv
// Shared definitions for the exponent normalisation pipeline:
// operation encodings and a small classification helper.
package exp_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_DEC = 2'b10,
        OP_INC = 2'b11
    } exp_op_e;

    // ADD and INC can only run off the top of the exponent range;
    // SUB and DEC can only run off the bottom.
    function automatic logic op_counts_up(input exp_op_e op);
        return (op == OP_ADD) || (op == OP_INC);
    endfunction

endpackage

// File: rtl/exp_arith.sv
// Combinational exponent arithmetic. The result is carried in EW+2 bits,
// signed, so that both a carry past the top and a borrow below zero are
// visible to the classification stage.
module exp_arith #(
    parameter int EW = 8,
    parameter int SW = 5
) (
    input  logic [1:0]           op_i,
    input  logic [EW-1:0]        a_i,
    input  logic [EW-1:0]        b_i,
    input  logic [SW-1:0]        shift_i,
    output logic signed [EW+1:0] sum_o
);
    import exp_pkg::*;

    localparam logic signed [EW+1:0] ONE = {{(EW+1){1'b0}}, 1'b1};

    logic signed [EW+1:0] a_ext;
    logic signed [EW+1:0] b_ext;
    logic signed [EW+1:0] sh_ext;

    assign a_ext  = $signed({2'b00, a_i});
    assign b_ext  = $signed({2'b00, b_i});
    assign sh_ext = $signed({{(EW+2-SW){1'b0}}, shift_i});

    // Select the operation; zero-extended operands keep the math exact.
    always_comb begin
        sum_o = a_ext;
        unique case (exp_op_e'(op_i))
            OP_ADD: sum_o = a_ext + b_ext;
            OP_SUB: sum_o = a_ext - b_ext;
            OP_DEC: sum_o = a_ext - sh_ext;
            OP_INC: sum_o = a_ext + ONE;
        endcase
    end

endmodule

// File: rtl/exp_norm_pipe.sv
// Two-stage exponent normalisation pipeline with valid/ready handshakes.
// S1 holds the raw EW+2-bit sum and the op; S2 holds the classified,
// optionally saturated result and its flags. Sticky flags accumulate
// overflow/underflow of results that actually leave the block.
module exp_norm_pipe #(
    parameter int EW  = 8,
    parameter int SW  = 5,
    parameter int SAT = 1
) (
    input  logic          clk,
    input  logic          rst,          // active-low, asynchronous assert
    input  logic          valid_i,
    output logic          ready_o,
    input  logic [1:0]    op_i,
    input  logic [EW-1:0] data_a_i,
    input  logic [EW-1:0] data_b_i,
    input  logic [SW-1:0] shift_i,
    input  logic          flush_i,
    input  logic          clr_i,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [EW-1:0] result_o,
    output logic          ovf_o,
    output logic          unf_o,
    output logic          zero_o,
    output logic          ovf_sticky_o,
    output logic          unf_sticky_o
);
    import exp_pkg::*;

    localparam logic signed [EW+1:0] MAX_EXP = {2'b00, {EW{1'b1}}};
    localparam logic signed [EW+1:0] ZERO_S  = '0;
    localparam bit                   SAT_EN  = (SAT != 0);

    // Stage 1 state
    logic                 s1_valid_q, s1_valid_d;
    logic signed [EW+1:0] s1_sum_q, s1_sum_d;
    exp_op_e              s1_op_q, s1_op_d;

    // Stage 2 state
    logic                 s2_valid_q, s2_valid_d;
    logic [EW-1:0]        res_q, res_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;
    logic                 zero_q, zero_d;

    // Sticky flags
    logic                 ovf_sticky_q, ovf_sticky_d;
    logic                 unf_sticky_q, unf_sticky_d;

    // Handshake
    logic                 s2_ready;
    logic                 s1_advance;
    logic                 accept;
    logic                 xfer;

    // Classification of the S1 contents
    logic                 cls_up;
    logic                 cls_ovf;
    logic                 cls_unf;
    logic [EW-1:0]        cls_res;
    logic                 cls_zero;

    logic signed [EW+1:0] arith_sum;

    exp_arith #(
        .EW (EW),
        .SW (SW)
    ) u_arith (
        .op_i    (op_i),
        .a_i     (data_a_i),
        .b_i     (data_b_i),
        .shift_i (shift_i),
        .sum_o   (arith_sum)
    );

    assign s2_ready   = !s2_valid_q || ready_i;
    assign s1_advance = s2_ready;
    assign ready_o    = !s1_valid_q || s1_advance;
    assign accept     = valid_i && ready_o;
    assign xfer       = s2_valid_q && ready_i;

    // Classify the raw sum and apply saturation when enabled.
    always_comb begin
        cls_up  = op_counts_up(s1_op_q);
        cls_ovf = cls_up && (s1_sum_q >= MAX_EXP);
        cls_unf = !cls_up && (s1_sum_q <= ZERO_S);
        cls_res = s1_sum_q[EW-1:0];
        if (SAT_EN) begin
            if (cls_ovf) begin
                cls_res = {EW{1'b1}};
            end else if (cls_unf) begin
                cls_res = '0;
            end
        end
        cls_zero = (cls_res == '0);
    end

    // Next-state for both stages and the sticky flags.
    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_sum_d     = s1_sum_q;
        s1_op_d      = s1_op_q;
        s2_valid_d   = s2_valid_q;
        res_d        = res_q;
        ovf_d        = ovf_q;
        unf_d        = unf_q;
        zero_d       = zero_q;
        ovf_sticky_d = ovf_sticky_q;
        unf_sticky_d = unf_sticky_q;

        // Operands are captured only on an accepted input, so idle
        // inputs never disturb the held stage contents.
        if (accept) begin
            s1_sum_d = arith_sum;
            s1_op_d  = exp_op_e'(op_i);
        end
        if (ready_o) begin
            s1_valid_d = valid_i;
        end

        if (s2_ready) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                res_d  = cls_res;
                ovf_d  = cls_ovf;
                unf_d  = cls_unf;
                zero_d = cls_zero;
            end
        end

        // A set from a departing flagged result wins over a clear.
        if (!flush_i) begin
            ovf_sticky_d = (ovf_sticky_q && !clr_i) || (xfer && ovf_q);
            unf_sticky_d = (unf_sticky_q && !clr_i) || (xfer && unf_q);
        end

        if (flush_i) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end
    end

    // Pipeline and sticky registers; reset empties the pipe and clears outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q   <= 1'b0;
            s1_sum_q     <= '0;
            s1_op_q      <= OP_ADD;
            s2_valid_q   <= 1'b0;
            res_q        <= '0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
            zero_q       <= 1'b0;
            ovf_sticky_q <= 1'b0;
            unf_sticky_q <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_sum_q     <= s1_sum_d;
            s1_op_q      <= s1_op_d;
            s2_valid_q   <= s2_valid_d;
            res_q        <= res_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
            zero_q       <= zero_d;
            ovf_sticky_q <= ovf_sticky_d;
            unf_sticky_q <= unf_sticky_d;
        end
    end

    assign valid_o      = s2_valid_q;
    assign result_o     = res_q;
    assign ovf_o        = ovf_q;
    assign unf_o        = unf_q;
    assign zero_o       = zero_q;
    assign ovf_sticky_o = ovf_sticky_q;
    assign unf_sticky_o = unf_sticky_q;

endmodule

// File: tb/tb_exp_norm_pipe.sv
// Bench for exp_norm_pipe: a saturating and a wrapping instance share the
// same stimulus and are both checked against a queue-based model.
module tb_exp_norm_pipe;

    localparam int EW = 8;
    localparam int SW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst     = 1'b1;
    logic       valid_i = 1'b0;
    logic       flush_i = 1'b0;
    logic       clr_i   = 1'b0;
    logic       ready_i = 1'b1;
    logic [1:0] op_i    = 2'b00;
    logic [7:0] a_i     = 8'h00;
    logic [7:0] b_i     = 8'h00;
    logic [4:0] sh_i    = 5'h00;

    logic       rdy_s, vld_s, ovf_s, unf_s, zero_s, ovs_s, uns_s;
    logic [7:0] res_s;
    logic       rdy_w, vld_w, ovf_w, unf_w, zero_w, ovs_w, uns_w;
    logic [7:0] res_w;

    exp_norm_pipe #(.EW(EW), .SW(SW), .SAT(1)) u_sat (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(rdy_s), .op_i(op_i),
        .data_a_i(a_i), .data_b_i(b_i), .shift_i(sh_i), .flush_i(flush_i),
        .clr_i(clr_i), .valid_o(vld_s), .ready_i(ready_i), .result_o(res_s),
        .ovf_o(ovf_s), .unf_o(unf_s), .zero_o(zero_s),
        .ovf_sticky_o(ovs_s), .unf_sticky_o(uns_s)
    );

    exp_norm_pipe #(.EW(EW), .SW(SW), .SAT(0)) u_wrap (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(rdy_w), .op_i(op_i),
        .data_a_i(a_i), .data_b_i(b_i), .shift_i(sh_i), .flush_i(flush_i),
        .clr_i(clr_i), .valid_o(vld_w), .ready_i(ready_i), .result_o(res_w),
        .ovf_o(ovf_w), .unf_o(unf_w), .zero_o(zero_w),
        .ovf_sticky_o(ovs_w), .unf_sticky_o(uns_w)
    );

    int n_cmp  = 0;
    int n_err  = 0;
    int cyc    = 0;
    int n_xfer = 0;
    bit saw_stall = 1'b0;

    typedef struct {
        int         cyc;
        logic [7:0] rs;
        logic [7:0] rw;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t q[$];
    logic m_ovs = 1'b0;
    logic m_uns = 1'b0;

    // op, a, b, shift, sat result, wrap result, ovf, unf (hand-computed)
    int vt [13][8] = '{
        '{0, 'h80, 'h7E, 'h00, 'hFE, 'hFE, 0, 0},
        '{0, 'h80, 'h7F, 'h00, 'hFF, 'hFF, 1, 0},
        '{0, 'hFF, 'h02, 'h00, 'hFF, 'h01, 1, 0},
        '{1, 'h05, 'h06, 'h00, 'h00, 'hFF, 0, 1},
        '{1, 'h05, 'h05, 'h00, 'h00, 'h00, 0, 1},
        '{2, 'h10, 'h00, 'h0F, 'h01, 'h01, 0, 0},
        '{3, 'hFE, 'h00, 'h00, 'hFF, 'hFF, 1, 0},
        '{3, 'h10, 'h00, 'h00, 'h11, 'h11, 0, 0},
        '{3, 'hFF, 'h00, 'h00, 'hFF, 'h00, 1, 0},
        '{2, 'h03, 'h00, 'h1F, 'h00, 'hE4, 0, 1},
        '{1, 'h00, 'hFF, 'h00, 'h00, 'h01, 0, 1},
        '{2, 'h20, 'h00, 'h1F, 'h01, 'h01, 0, 0},
        '{0, 'h00, 'h00, 'h00, 'h00, 'h00, 0, 0}
    };

    task automatic chk1(input string name, input logic act, input logic req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %0b required %0b (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %02h required %02h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic chki(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    // Reference arithmetic straight from the operation definitions.
    function automatic void model(input logic [1:0] op, input logic [7:0] a,
                                  input logic [7:0] b, input logic [4:0] sh,
                                  output logic [7:0] rs, output logic [7:0] rw,
                                  output logic ovf, output logic unf);
        int t;
        case (op)
            2'b00:   t = int'(a) + int'(b);
            2'b01:   t = int'(a) - int'(b);
            2'b10:   t = int'(a) - int'(sh);
            default: t = int'(a) + 1;
        endcase
        ovf = (op == 2'b00 || op == 2'b11) && (t >= 255);
        unf = (op == 2'b01 || op == 2'b10) && (t <= 0);
        rw  = t[7:0];
        rs  = ovf ? 8'hFF : (unf ? 8'h00 : rw);
    endfunction

    // Per-cycle compare against the model, then advance the model by
    // what the coming rising edge will do.
    always @(negedge clk) begin : p_check
        logic [7:0] rs, rw;
        logic       ovf, unf;
        bit         ev, er, xf, ac;
        exp_t       e;
        cyc++;
        if (!rst) begin
            chk1("rst_valid_s", vld_s, 1'b0);  chk1("rst_valid_w", vld_w, 1'b0);
            chk1("rst_ready_s", rdy_s, 1'b1);  chk1("rst_ready_w", rdy_w, 1'b1);
            chk8("rst_result_s", res_s, 8'h00); chk8("rst_result_w", res_w, 8'h00);
            chk1("rst_ovf_s", ovf_s, 1'b0);    chk1("rst_unf_s", unf_s, 1'b0);
            chk1("rst_zero_s", zero_s, 1'b0);  chk1("rst_zero_w", zero_w, 1'b0);
            chk1("rst_ovs_s", ovs_s, 1'b0);    chk1("rst_uns_s", uns_s, 1'b0);
            q.delete();
            m_ovs = 1'b0;
            m_uns = 1'b0;
        end else begin
            ev = (q.size() > 0) && (cyc - q[0].cyc >= 2);
            er = (q.size() < 2) || ready_i;
            if (!rdy_s) saw_stall = 1'b1;
            chk1("valid_s", vld_s, ev);   chk1("valid_w", vld_w, ev);
            chk1("ready_s", rdy_s, er);   chk1("ready_w", rdy_w, er);
            chk1("ovs_s", ovs_s, m_ovs);  chk1("uns_s", uns_s, m_uns);
            chk1("ovs_w", ovs_w, m_ovs);  chk1("uns_w", uns_w, m_uns);
            if (ev) begin
                chk8("result_s", res_s, q[0].rs);
                chk8("result_w", res_w, q[0].rw);
                chk1("ovf_s", ovf_s, q[0].ovf);  chk1("ovf_w", ovf_w, q[0].ovf);
                chk1("unf_s", unf_s, q[0].unf);  chk1("unf_w", unf_w, q[0].unf);
                chk1("zero_s", zero_s, q[0].rs == 8'h00);
                chk1("zero_w", zero_w, q[0].rw == 8'h00);
            end
            xf = ev && ready_i;
            ac = valid_i && er && !flush_i;
            if (!flush_i) begin
                m_ovs = (m_ovs && !clr_i) || (xf && q[0].ovf);
                m_uns = (m_uns && !clr_i) || (xf && q[0].unf);
            end
            if (xf) begin
                $display("xfer %0d: sat=%02h wrap=%02h ovf=%0b unf=%0b",
                         n_xfer, q[0].rs, q[0].rw, q[0].ovf, q[0].unf);
                void'(q.pop_front());
                n_xfer++;
            end
            if (flush_i) q.delete();
            if (ac) begin
                model(op_i, a_i, b_i, sh_i, rs, rw, ovf, unf);
                e.cyc = cyc; e.rs = rs; e.rw = rw; e.ovf = ovf; e.unf = unf;
                q.push_back(e);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Present one operation and hold it until accepted; scramble idle data.
    task automatic send(input int op, input int a, input int b, input int sh);
        bit acc = 1'b0;
        int n   = 0;
        valid_i = 1'b1;
        op_i = 2'(op); a_i = 8'(a); b_i = 8'(b); sh_i = 5'(sh);
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = rdy_s && !flush_i;
            @(posedge clk);
            #2;
            n++;
        end
        if (!acc) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: accepted %0b required 1", acc);
        end
        valid_i = 1'b0;
        op_i = 2'($urandom); a_i = 8'($urandom); b_i = 8'($urandom); sh_i = 5'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        ready_i = 1'b1;
        while (q.size() > 0 && n < 30) begin
            step(1);
            n++;
        end
        if (q.size() > 0) begin
            n_cmp++; n_err++;
            $display("FAIL drain_timeout: pending %0d required 0", q.size());
        end
        step(1);
    endtask

    task automatic reset_zero_check(input string tag);
        chk1({tag, "_valid_s"}, vld_s, 1'b0);   chk1({tag, "_valid_w"}, vld_w, 1'b0);
        chk8({tag, "_result_s"}, res_s, 8'h00); chk8({tag, "_result_w"}, res_w, 8'h00);
        chk1({tag, "_ovf_s"}, ovf_s, 1'b0);     chk1({tag, "_unf_w"}, unf_w, 1'b0);
        chk1({tag, "_zero_s"}, zero_s, 1'b0);   chk1({tag, "_ovs_s"}, ovs_s, 1'b0);
        chk1({tag, "_uns_s"}, uns_s, 1'b0);     chk1({tag, "_ready_s"}, rdy_s, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : p_main
        logic [7:0] rs, rw;
        logic       ovf, unf;
        int         x0;

        // Power-up reset
        #1 rst = 1'b0;
        step(3);
        reset_zero_check("reset");
        rst = 1'b1;
        step(1);
        chk1("ready_after_reset", rdy_s, 1'b1);

        // Directed vectors, streamed; each pins the model to a literal
        for (int i = 0; i < 13; i++) begin
            model(2'(vt[i][0]), 8'(vt[i][1]), 8'(vt[i][2]), 5'(vt[i][3]), rs, rw, ovf, unf);
            chk8("pin_sat", rs, 8'(vt[i][4]));
            chk8("pin_wrap", rw, 8'(vt[i][5]));
            chk1("pin_ovf", ovf, vt[i][6] != 0);
            chk1("pin_unf", unf, vt[i][7] != 0);
            send(vt[i][0], vt[i][1], vt[i][2], vt[i][3]);
        end
        drain();

        // Back-to-back with downstream stalled for cycles 2-4
        saw_stall = 1'b0;
        x0 = n_xfer;
        fork
            begin
                send(0, 'h10, 'h20, 0);
                send(1, 'h40, 'h01, 0);
                send(3, 'h7F, 0, 0);
                send(2, 'h30, 0, 'h05);
            end
            begin
                ready_i = 1'b1;
                step(1);
                ready_i = 1'b0;
                step(3);
                ready_i = 1'b1;
            end
        join
        drain();
        chk1("b2b_stall_seen", saw_stall, 1'b1);
        chki("b2b_delivered", n_xfer - x0, 4);

        // Sticky flags
        clr_i = 1'b1;
        step(1);
        clr_i = 1'b0;
        chk1("sticky_clr_init", ovs_s, 1'b0);
        send(0, 'h80, 'h7F, 0);
        drain();
        chk1("sticky_ovf_set", ovs_s, 1'b1);
        clr_i = 1'b1;
        step(1);
        clr_i = 1'b0;
        chk1("sticky_clr_alone", ovs_s, 1'b0);
        ready_i = 1'b0;
        send(0, 'h80, 'h7F, 0);
        step(1);
        chk1("held_valid", vld_s, 1'b1);
        chk1("sticky_before_xfer", ovs_s, 1'b0);
        clr_i   = 1'b1;
        ready_i = 1'b1;
        step(1);
        clr_i = 1'b0;
        chk1("sticky_clr_with_xfer", ovs_s, 1'b1);
        send(1, 'h05, 'h06, 0);
        drain();
        chk1("sticky_unf_set", uns_s, 1'b1);

        // Asynchronous reset with both stages full
        ready_i = 1'b0;
        send(0, 'h80, 'h7E, 0);
        send(3, 'h10, 0, 0);
        chk1("full_before_rst", rdy_s, 1'b0);
        rst = 1'b0;
        #1;
        reset_zero_check("async_rst");
        ready_i = 1'b1;
        step(2);
        rst = 1'b1;
        x0 = n_xfer;
        step(6);
        chki("no_stale_after_rst", n_xfer - x0, 0);

        // Flush with both stages full; sticky flags must survive
        send(0, 'hFF, 'h02, 0);
        drain();
        chk1("sticky_before_flush", ovs_s, 1'b1);
        ready_i = 1'b0;
        send(1, 'h20, 'h01, 0);
        send(2, 'h20, 0, 'h02);
        flush_i = 1'b1;
        valid_i = 1'b1;
        op_i = 2'b00; a_i = 8'h01; b_i = 8'h01;
        step(1);
        flush_i = 1'b0;
        valid_i = 1'b0;
        chk1("flush_valid", vld_s, 1'b0);
        chk1("flush_ready", rdy_s, 1'b1);
        ready_i = 1'b1;
        x0 = n_xfer;
        step(6);
        chki("no_stale_after_flush", n_xfer - x0, 0);
        chk1("sticky_kept_flush", ovs_s, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
